// File: rtl/mem_stage_wb_if.sv
// Data-memory request/acknowledge bundle between the memory stage and data memory.
// The stage is the master; the memory (or its model) is the slave.
interface mem_stage_wb_if #(
    parameter int SIZE = 32
);
    logic            DMemReq;
    logic            DMemWe;
    logic [SIZE-1:0] DMemAddr;
    logic [SIZE-1:0] DMemWData;
    logic [SIZE-1:0] DMemRData;
    logic            DMemAck;

    modport master (
        output DMemReq, DMemWe, DMemAddr, DMemWData,
        input  DMemRData, DMemAck
    );

    modport slave (
        input  DMemReq, DMemWe, DMemAddr, DMemWData,
        output DMemRData, DMemAck
    );
endinterface

// File: rtl/mem_stage_wb.sv
// Memory stage: data-memory handshake with timeout abort, pipeline stall,
// and the MEM/WB register feeding writeback.
module mem_stage_wb #(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            PCSrcM,
    input  logic            RegWriteM,
    input  logic            MemToRegM,
    input  logic            MemWriteM,
    input  logic [3:0]      WA3M,
    input  logic [SIZE-1:0] ALUOutM,
    input  logic [SIZE-1:0] WriteDataM,
    mem_stage_wb_if.master  dmem,
    output logic            StallM,
    output logic            PCSrcW,
    output logic            RegWriteW,
    output logic            MemToRegW,
    output logic [3:0]      WA3W,
    output logic [SIZE-1:0] ALUOutW,
    output logic [SIZE-1:0] ReadDataW,
    output logic [SIZE-1:0] ResultW,
    output logic            MemFaultW
);
    // state  | meaning
    // S_IDLE | no access outstanding; a memop issues its request this cycle
    // S_WAIT | request outstanding, driven from the latched copy, counting toward abort
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            drop;
    logic            lat_we, lat_pcsrc, lat_regwrite, lat_memtoreg;
    logic [3:0]      lat_wa3;
    logic [SIZE-1:0] lat_addr, lat_wdata, lat_aluout;

    logic            memop;
    logic            in_wait;
    logic            req;

    // The cycle after an abort still presents the dropped instruction; drop masks it.
    assign memop   = (MemToRegM | MemWriteM) & ~drop;
    assign in_wait = (state == S_WAIT);
    assign req     = RST_N & (in_wait | memop);

    assign dmem.DMemReq   = req;
    assign dmem.DMemWe    = in_wait ? lat_we    : MemWriteM;
    assign dmem.DMemAddr  = in_wait ? lat_addr  : {ALUOutM[SIZE-1:2], 2'b00};
    assign dmem.DMemWData = in_wait ? lat_wdata : WriteDataM;
    assign StallM         = req & ~dmem.DMemAck;

    assign ResultW = MemToRegW ? ReadDataW : ALUOutW;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            cnt          <= '0;
            drop         <= 1'b0;
            MemFaultW    <= 1'b0;
            PCSrcW       <= 1'b0;
            RegWriteW    <= 1'b0;
            MemToRegW    <= 1'b0;
            WA3W         <= '0;
            ALUOutW      <= '0;
            ReadDataW    <= '0;
            lat_we       <= 1'b0;
            lat_pcsrc    <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_wa3      <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_aluout   <= '0;
        end else begin
            drop      <= 1'b0;
            PCSrcW    <= 1'b0;
            RegWriteW <= 1'b0;
            MemToRegW <= 1'b0;
            WA3W      <= '0;
            ALUOutW   <= '0;
            ReadDataW <= '0;
            case (state)
                S_IDLE: begin
                    if (drop) begin
                        state <= S_IDLE;
                    end else if (!memop) begin
                        PCSrcW    <= PCSrcM;
                        RegWriteW <= RegWriteM;
                        MemToRegW <= MemToRegM;
                        WA3W      <= WA3M;
                        ALUOutW   <= ALUOutM;
                    end else begin
                        lat_we       <= MemWriteM;
                        lat_pcsrc    <= PCSrcM;
                        lat_regwrite <= RegWriteM;
                        lat_memtoreg <= MemToRegM;
                        lat_wa3      <= WA3M;
                        lat_addr     <= {ALUOutM[SIZE-1:2], 2'b00};
                        lat_wdata    <= WriteDataM;
                        lat_aluout   <= ALUOutM;
                        if (dmem.DMemAck) begin
                            PCSrcW    <= PCSrcM;
                            RegWriteW <= RegWriteM;
                            MemToRegW <= MemToRegM;
                            WA3W      <= WA3M;
                            ALUOutW   <= ALUOutM;
                            ReadDataW <= MemToRegM ? dmem.DMemRData : '0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack takes priority over a simultaneous timeout.
                    if (dmem.DMemAck) begin
                        PCSrcW    <= lat_pcsrc;
                        RegWriteW <= lat_regwrite;
                        MemToRegW <= lat_memtoreg;
                        WA3W      <= lat_wa3;
                        ALUOutW   <= lat_aluout;
                        ReadDataW <= lat_memtoreg ? dmem.DMemRData : '0;
                        state     <= S_IDLE;
                        cnt       <= '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        MemFaultW <= 1'b1;
                        drop      <= 1'b1;
                        state     <= S_IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed bench for mem_stage_wb (TIMEOUT=4): pass-through, zero-wait load,
// waited store, timeout abort, reset mid-wait and ack-at-timeout.
module tb_mem_stage_wb;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        PCSrcM, RegWriteM, MemToRegM, MemWriteM;
    logic [3:0]  WA3M;
    logic [31:0] ALUOutM, WriteDataM;
    logic        StallM, PCSrcW, RegWriteW, MemToRegW, MemFaultW;
    logic [3:0]  WA3W;
    logic [31:0] ALUOutW, ReadDataW, ResultW;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_wb_if #(.SIZE(32)) dmem ();

    mem_stage_wb #(.SIZE(32), .TIMEOUT(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PCSrcM     (PCSrcM),
        .RegWriteM  (RegWriteM),
        .MemToRegM  (MemToRegM),
        .MemWriteM  (MemWriteM),
        .WA3M       (WA3M),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .dmem       (dmem),
        .StallM     (StallM),
        .PCSrcW     (PCSrcW),
        .RegWriteW  (RegWriteW),
        .MemToRegW  (MemToRegW),
        .WA3W       (WA3W),
        .ALUOutW    (ALUOutW),
        .ReadDataW  (ReadDataW),
        .ResultW    (ResultW),
        .MemFaultW  (MemFaultW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_m(input logic pcs, input logic rw, input logic m2r, input logic mw,
                         input logic [3:0] wa, input logic [31:0] alu, input logic [31:0] wd);
        PCSrcM = pcs; RegWriteM = rw; MemToRegM = m2r; MemWriteM = mw;
        WA3M = wa; ALUOutM = alu; WriteDataM = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        dmem.DMemAck = 1'b0;
        dmem.DMemRData = 32'h0;
        set_m(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

        // 1. reset
        #1;
        check("rst_req", 32'(dmem.DMemReq), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        tick();
        tick();
        check("rst_req2", 32'(dmem.DMemReq), 32'd0);
        check("rst_regwrite", 32'(RegWriteW), 32'd0);
        check("rst_result", ResultW, 32'h0);
        check("rst_wa3", 32'(WA3W), 32'h0);
        check("rst_fault", 32'(MemFaultW), 32'd0);

        // 2. ALU pass-through
        RST_N = 1'b1;
        set_m(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 32'h0000_00A5, 32'h0);
        #1;
        check("alu_req", 32'(dmem.DMemReq), 32'd0);
        check("alu_stall", 32'(StallM), 32'd0);
        tick();
        check("alu_regwrite", 32'(RegWriteW), 32'd1);
        check("alu_wa3", 32'(WA3W), 32'h3);
        check("alu_result", ResultW, 32'hA5);
        check("alu_rdata", ReadDataW, 32'h0);

        // 3. zero-wait load
        set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 32'h100, 32'h0);
        dmem.DMemAck = 1'b1;
        dmem.DMemRData = 32'hDEADBEEF;
        #1;
        check("ld0_req", 32'(dmem.DMemReq), 32'd1);
        check("ld0_addr", dmem.DMemAddr, 32'h100);
        check("ld0_we", 32'(dmem.DMemWe), 32'd0);
        check("ld0_stall", 32'(StallM), 32'd0);
        tick();
        check("ld0_result", ResultW, 32'hDEADBEEF);
        check("ld0_memtoreg", 32'(MemToRegW), 32'd1);
        check("ld0_wa3", 32'(WA3W), 32'h5);

        // 4. store with 3 wait cycles
        set_m(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h203, 32'h1234);
        dmem.DMemAck = 1'b0;
        dmem.DMemRData = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem.DMemAck = 1'b1;
            #1;
            check("st_req", 32'(dmem.DMemReq), 32'd1);
            check("st_addr", dmem.DMemAddr, 32'h200);
            check("st_we", 32'(dmem.DMemWe), 32'd1);
            check("st_wdata", dmem.DMemWData, 32'h1234);
            check("st_stall", 32'(StallM), (i < 3) ? 32'd1 : 32'd0);
            tick();
            check("st_regwrite", 32'(RegWriteW), 32'd0);
            check("st_aluout", ALUOutW, (i < 3) ? 32'h0 : 32'h203);
        end
        check("st_rdata", ReadDataW, 32'h0);

        // 5. timeout abort
        set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 32'h40, 32'h0);
        dmem.DMemAck = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("to_req", 32'(dmem.DMemReq), 32'd1);
            check("to_stall", 32'(StallM), 32'd1);
            tick();
            check("to_regwrite", 32'(RegWriteW), 32'd0);
            check("to_fault", 32'(MemFaultW), (i < 4) ? 32'd0 : 32'd1);
        end
        #1;
        check("to_post_req", 32'(dmem.DMemReq), 32'd0);
        check("to_post_stall", 32'(StallM), 32'd0);
        tick();
        check("to_drop_regwrite", 32'(RegWriteW), 32'd0);
        set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'h7, 32'h44, 32'h0);
        dmem.DMemAck = 1'b1;
        dmem.DMemRData = 32'hCAFEF00D;
        tick();
        check("to_next_result", ResultW, 32'hCAFEF00D);
        check("to_next_regwrite", 32'(RegWriteW), 32'd1);
        check("to_fault_sticky", 32'(MemFaultW), 32'd1);

        // 6. reset mid-WAIT
        set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 32'h80, 32'h0);
        dmem.DMemAck = 1'b0;
        tick();
        tick();
        RST_N = 1'b0;
        #1;
        check("rw_req", 32'(dmem.DMemReq), 32'd0);
        check("rw_stall", 32'(StallM), 32'd0);
        tick();
        check("rw_fault", 32'(MemFaultW), 32'd0);
        check("rw_regwrite", 32'(RegWriteW), 32'd0);
        RST_N = 1'b1;
        dmem.DMemAck = 1'b1;
        dmem.DMemRData = 32'h600DF00D;
        #1;
        check("rw_ld_req", 32'(dmem.DMemReq), 32'd1);
        check("rw_ld_stall", 32'(StallM), 32'd0);
        check("rw_ld_addr", dmem.DMemAddr, 32'h80);
        tick();
        check("rw_ld_result", ResultW, 32'h600DF00D);
        check("rw_ld_wa3", 32'(WA3W), 32'h8);

        // 7. ack on the last WAIT cycle wins over timeout
        set_m(1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 32'h13, 32'h0);
        dmem.DMemAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ak_stall", 32'(StallM), 32'd1);
            tick();
        end
        dmem.DMemAck = 1'b1;
        dmem.DMemRData = 32'h12345678;
        #1;
        check("ak_addr", dmem.DMemAddr, 32'h10);
        check("ak_stall_last", 32'(StallM), 32'd0);
        tick();
        check("ak_result", ResultW, 32'h12345678);
        check("ak_regwrite", 32'(RegWriteW), 32'd1);
        check("ak_fault", 32'(MemFaultW), 32'd0);

        set_m(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        dmem.DMemAck = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_wb.md
Name: mem_stage_wb

Overview:
Memory stage of the pipelined core. It sits directly downstream of the EX/MEM register and consumes its M-suffixed outputs. It drives the data-memory request/acknowledge handshake for loads and stores and stalls the front of the pipe while an access is outstanding. It registers the results into the MEM/WB boundary that feeds the writeback stage.

Parameters:
SIZE, 32, datapath width in bits
TIMEOUT, 15, maximum WAIT-state cycles without DMemAck before the access is aborted (must be >= 1)

Ports:
CLK  in  1  clock; all state updates on posedge
RST_N  in  1  synchronous active-low reset
PCSrcM  in  1  branch/PC-write control from EX/MEM
RegWriteM  in  1  register-file write enable from EX/MEM
MemToRegM  in  1  load instruction; result is taken from memory
MemWriteM  in  1  store instruction
WA3M  in  4  destination register
ALUOutM  in  SIZE  address for memory ops, or ALU result
WriteDataM  in  SIZE  store data
DMemReq  out  1  memory request
DMemWe  out  1  1 = store, 0 = load
DMemAddr  out  SIZE  word-aligned address
DMemWData  out  SIZE  store data to memory
DMemRData  in  SIZE  load data, valid when DMemAck=1
DMemAck  in  1  access complete this cycle
StallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
PCSrcW  out  1  registered PCSrc
RegWriteW  out  1  registered RegWrite
MemToRegW  out  1  registered MemToReg
WA3W  out  4  registered destination register
ALUOutW  out  SIZE  registered ALU result
ReadDataW  out  SIZE  registered load data
ResultW  out  SIZE  MemToRegW ? ReadDataW : ALUOutW (combinational)
MemFaultW  out  1  sticky flag for an access timeout

Behaviour:
- Reset (RST_N=0 at posedge):
  - FSM goes to IDLE; wait counter = 0.
  - All W outputs and MemFaultW = 0.
  - While RST_N=0, DMemReq and StallM are forced to 0 combinationally.
- memop = MemToRegM | MemWriteM. MemToRegM and MemWriteM are never both 1.
- FSM has two states, IDLE and WAIT. The counter width is $clog2(TIMEOUT+1).
- IDLE with memop=0:
  - No request.
  - At the next edge, the W registers load PCSrc/RegWrite/MemToReg/WA3/ALUOut from the M inputs; ReadDataW = 0.
  - Latency is 1 cycle.
- IDLE with memop=1:
  - DMemReq=1 combinationally in the same cycle.
  - DMemAddr = {ALUOutM[SIZE-1:2], 2'b00}; ALUOutM[1:0] is ignored.
  - DMemWe = MemWriteM; DMemWData = WriteDataM.
  - The request fields are also latched internally.
  - If DMemAck=1: zero-wait completion. The W registers load at the edge; ReadDataW = DMemRData for a load, 0 for a store. StallM = 0. Stay in IDLE.
  - If DMemAck=0: StallM=1. Go to WAIT with counter = 0. The W registers load a bubble (RegWriteW=0, PCSrcW=0, MemToRegW=0, WA3W=0, ALUOutW=0, ReadDataW=0).
- WAIT:
  - DMemReq=1; DMemWe, DMemAddr and DMemWData are driven from the latched copies.
  - StallM = ~DMemAck.
  - On DMemAck=1: complete exactly as the zero-wait case, using the latched fields (upstream is frozen, so the M inputs match). Return to IDLE.
  - On DMemAck=0 with counter < TIMEOUT-1: counter increments; W outputs get a bubble.
  - On DMemAck=0 with counter == TIMEOUT-1: abort. MemFaultW <= 1, W outputs get a bubble, return to IDLE, and the instruction is dropped.
  - The WAIT state therefore lasts at most TIMEOUT cycles.
  - If DMemAck and the timeout occur in the same cycle, the ack wins.
- After an abort:
  - StallM is 1 through the abort cycle and 0 on the following cycle. The EX/MEM register then advances.
  - MemFaultW stays 1 until reset.
- Stalled cycles never produce a W write: a memop reaches the W registers exactly once, on its completion edge.
- Reset asserted mid-WAIT: at the next edge go to IDLE, counter = 0, request dropped, MemFaultW cleared. No completion is issued.
- No X propagation: ReadDataW is never loaded from DMemRData unless DMemAck=1.

Test Plan:
1. RST_N=0 for 2 cycles with MemToRegM=1, DMemAck=0 -> DMemReq=0, StallM=0, all W outputs 0, MemFaultW=0.
2. ALU pass-through: RegWriteM=1, WA3M=4'h3, ALUOutM=32'h0000_00A5 -> next cycle RegWriteW=1, WA3W=3, ResultW=32'hA5, DMemReq never 1, StallM=0.
3. Zero-wait load: MemToRegM=1, RegWriteM=1, ALUOutM=32'h100, DMemAck=1 with DMemRData=32'hDEADBEEF in the same cycle -> DMemAddr=32'h100, DMemWe=0, StallM=0, next cycle ResultW=32'hDEADBEEF.
4. Store with 3 wait cycles: MemWriteM=1, ALUOutM=32'h203, WriteDataM=32'h1234, ack on the 4th request cycle -> DMemAddr=32'h200, DMemWe=1, DMemWData=32'h1234 held for 4 cycles, StallM=1 for 3 cycles then 0 on the ack cycle, RegWriteW=0 throughout.
5. Timeout with TIMEOUT=4: load, DMemAck held 0 -> DMemReq and StallM high for 5 cycles (IDLE + 4 WAIT), then MemFaultW=1 and DMemReq=0. MemFaultW stays 1 through a subsequent successful access.
6. Reset mid-WAIT: RST_N=0 on the 2nd WAIT cycle -> next edge DMemReq=0, StallM=0, counter=0, MemFaultW=0. A load issued afterwards with immediate ack completes normally.
